mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the multicycle CPU's MEM-stage control and the byte-addressed, big-endian `DataMemory`. It turns one request (byte, halfword or word, load or store) into one or two word-wide memory cycles. Sub-word stores use read-modify-write. Sub-word loads get byte-lane extraction and sign/zero extension. Results and completion are reported to the control FSM with a Start/Busy/Done handshake.

## Interface
- No parameters.
- `CLK` in 1: system clock; all state changes on rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Start` in 1: request strobe, sampled only in IDLE.
- `Write` in 1: 1 = store, 0 = load.
- `Size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `Signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `Addr` in 32: byte address.
- `WData` in 32: store data, right-justified for sub-word sizes.
- `Busy` out 1: high whenever state ≠ IDLE.
- `Done` out 1: one-cycle completion pulse.
- `Fault` out 1: qualifies `Done`; request rejected.
- `LoadData` out 32: extended load result; holds until the next load completes.
- `RD` out 1: memory read enable, active-low.
- `WR` out 1: memory write enable, active-low.
- `DAddr` out 32: word-aligned memory address.
- `DataIn` out 32: word to memory.
- `DataOut` in 32: word from memory.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE, `Start`=1:
  - Request is latched (`Write`, `Size`, `Signed`, byte offset `Addr[1:0]`, `WData`).
  - `DAddr` ← `{Addr[31:2],2'b00}`.
  - Next state:
    - Fault condition: → DONE with `Fault`=1.
    - Load: → READ.
    - Word store: → WRITE, `DataIn` ← `WData`.
    - Sub-word store: → READ.
- READ:
  - `RD`=0 for the whole cycle.
  - At the closing edge, `DataOut` is captured into the internal word register.
  - Load: → DONE, with `LoadData` updated at the same edge.
  - Sub-word store: → WRITE, with `DataIn` ← merged word.
- WRITE: `WR`=0 for the whole cycle; → DONE.
- DONE: `Done`=1; → IDLE. `Start` is ignored here and in every non-IDLE state.
- Byte lanes are big-endian.
  - Byte offset 0 → bits [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - Halfword offset 0 → [31:16], offset 2 → [15:0].
- Merge replaces only the addressed lane with `WData[7:0]` or `WData[15:0]`; all other lanes are kept from the read word.
- Load extension: bit 7 (byte) or bit 15 (halfword) is replicated when `Signed`=1; zero-fill otherwise. Word loads ignore `Signed`.
- Fault conditions:
  - `Size`=11, always.
  - Misalignment, only when the alignment check is compiled in: halfword with `Addr[0]`=1, or word with `Addr[1:0]`≠0.
  - On fault: no memory cycle is issued, and `LoadData` is unchanged.
- `RD` and `WR` are never low in the same cycle.
- Reset values:
  - State IDLE.
  - `Busy`=0, `Done`=0, `Fault`=0.
  - `LoadData`=0, `DAddr`=0, `DataIn`=0.
  - `RD`=1, `WR`=1.
  - Internal registers 0.

## Timing
- `RD`, `WR`, `DAddr` and `DataIn` are registered and change only on the rising edge (or on reset). The memory samples them on the following falling edge.
- Read data is valid from that falling edge and is captured on the next rising edge.
- Latency from the `Start` sampling edge T0 to `Done` high:
  - Load: READ in T0–T1, `Done` in T1–T2.
  - Word store: WRITE in T0–T1, `Done` in T1–T2.
  - Sub-word store: READ, WRITE, then `Done` in T2–T3.
  - Fault: `Done`+`Fault` in T0–T1.
- `Fault` is high only while `Done` is high.
- Back-to-back: the earliest next `Start` is sampled at the edge ending DONE+1 (first IDLE cycle).
- Reset mid-operation:
  - `RD` and `WR` go high immediately, all outputs take reset values, and the state becomes IDLE.
  - A write whose WRITE cycle is reset before its falling edge does not occur.
  - A read-modify-write interrupted after READ leaves memory unchanged.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined:
  - Misaligned halfword and word requests raise `Fault` as above.
- Undefined:
  - No alignment check; only `Size`=11 faults.
  - Low address bits the size cannot use are ignored: word uses lane 0, halfword uses `Addr[1]` only, byte uses `Addr[1:0]`.

## Test plan
- Word store/load: Store word `Addr`=0x10, `WData`=0x11223344 → `WR` low one cycle, `Done` 2 cycles after `Start`. Then load word 0x10 → `LoadData`=0x11223344, `Done` after 2 cycles.
- Byte store/load: Store byte 0x11, `WData`=0x000000AA → READ then WRITE, `Done` after 3 cycles, word at 0x10 = 0x11AA3344. Unsigned byte load 0x11 → 0x000000AA; signed → 0xFFFFFFAA.
- Halfword store/load: Store halfword 0x12, `WData`=0x0000BEEF → word 0x11AABEEF. Signed halfword load 0x12 → 0xFFFFBEEF; unsigned → 0x0000BEEF.
- Misaligned word load 0x13:
  - With `MEM_ALIGN_CHECK_EN`: `Done`=`Fault`=1 one cycle after `Start`, `RD`/`WR` stay 1, `LoadData` unchanged.
  - Without the macro: `LoadData`=0x11AABEEF, `Fault`=0.
- Reset during WRITE: `Reset` pulsed during the WRITE cycle of a word store 0x20 ← 0xDEADBEEF, before the falling edge → `RD`=`WR`=1 at once, `Busy`=0, later load of 0x20 returns 0x00000000.
- `Start` while busy: `Start` held high through a byte store → no second access until IDLE, exactly one `Done` per accepted request, and the second request begins at the first IDLE edge.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of mem_access_unit.
// master: CPU control plus memory model; slave: the sequencer.
interface mem_access_unit_if;
  logic        Start;
  logic        Write;
  logic [1:0]  Size;
  logic        Signed;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [31:0] LoadData;
  logic        RD;
  logic        WR;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (
    output Start, Write, Size, Signed, Addr, WData, DataOut,
    input  Busy, Done, Fault, LoadData, RD, WR, DAddr, DataIn
  );

  modport slave (
    input  Start, Write, Size, Signed, Addr, WData, DataOut,
    output Busy, Done, Fault, LoadData, RD, WR, DAddr, DataIn
  );
endinterface

// File: rtl/mem_access_unit.sv
// Big-endian load/store sequencer: RMW sub-word stores, extended loads.
// Optional MEM_ALIGN_CHECK_EN faults misaligned halfword/word requests.
module mem_access_unit (
  input logic CLK,
  input logic Reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic [31:0] load_data_q, load_data_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] data_in_q, data_in_d;

  logic        req_fault;
  logic [4:0]  bshift;
  logic [4:0]  hshift;
  logic [31:0] sh_b;
  logic [31:0] sh_h;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;
  logic [31:0] merged;

  always_comb begin
    req_fault = (bus.Size == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
    if (bus.Size == 2'b01 && bus.Addr[0])
      req_fault = 1'b1;
    if (bus.Size == 2'b10 && bus.Addr[1:0] != 2'b00)
      req_fault = 1'b1;
`endif
  end

  // Lane 0 is the most significant byte.
  assign bshift = {~off_q, 3'b000};
  assign hshift = {~off_q[1], 4'b0000};
  assign sh_b   = bus.DataOut >> bshift;
  assign sh_h   = bus.DataOut >> hshift;
  assign lane_b = sh_b[7:0];
  assign lane_h = sh_h[15:0];

  always_comb begin
    case (size_q)
      2'b00:   ext = {{24{sgn_q & lane_b[7]}}, lane_b};
      2'b01:   ext = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: ext = bus.DataOut;
    endcase
  end

  always_comb begin
    if (size_q == 2'b00)
      merged = (bus.DataOut & ~(32'h0000_00ff << bshift))
             | ({24'b0, wdata_q[7:0]} << bshift);
    else
      merged = (bus.DataOut & ~(32'h0000_ffff << hshift))
             | ({16'b0, wdata_q} << hshift);
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    fault_d     = fault_q;
    load_data_d = load_data_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    daddr_d     = daddr_q;
    data_in_d   = data_in_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          write_d = bus.Write;
          size_d  = bus.Size;
          sgn_d   = bus.Signed;
          off_d   = bus.Addr[1:0];
          wdata_d = bus.WData[15:0];
          daddr_d = {bus.Addr[31:2], 2'b00};
          fault_d = 1'b0;
          if (req_fault) begin
            state_d = DONE;
            fault_d = 1'b1;
          end else if (!bus.Write) begin
            state_d = READ;
            rd_n_d  = 1'b0;
          end else if (bus.Size == 2'b10) begin
            state_d   = WRITE;
            wr_n_d    = 1'b0;
            data_in_d = bus.WData;
          end else begin
            state_d = READ;
            rd_n_d  = 1'b0;
          end
        end
      end
      READ: begin
        rd_n_d = 1'b1;
        if (write_q) begin
          state_d   = WRITE;
          wr_n_d    = 1'b0;
          data_in_d = merged;
        end else begin
          state_d     = DONE;
          load_data_d = ext;
        end
      end
      WRITE: begin
        wr_n_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        fault_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 16'h0;
      fault_q     <= 1'b0;
      load_data_q <= 32'h0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      daddr_q     <= 32'h0;
      data_in_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      daddr_q     <= daddr_d;
      data_in_q   <= data_in_d;
    end
  end

  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = (state_q == DONE);
  assign bus.Fault    = fault_q & (state_q == DONE);
  assign bus.LoadData = load_data_q;
  assign bus.RD       = rd_n_q;
  assign bus.WR       = wr_n_q;
  assign bus.DAddr    = daddr_q;
  assign bus.DataIn   = data_in_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a falling-edge
// big-endian word memory model.
module tb_mem_access_unit;

  logic CLK = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;
  int   bothlow = 0;
  int   badflt = 0;

  logic [31:0] mem [0:63] = '{default: 32'h0};

  mem_access_unit_if bus();

  mem_access_unit dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!bus.WR) mem[bus.DAddr[7:2]] <= bus.DataIn;
    if (!bus.RD) bus.DataOut <= mem[bus.DAddr[7:2]];
    if (!bus.RD && !bus.WR) bothlow++;
    if (bus.Fault && !bus.Done) badflt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output int lat,
                         output int rdl, output int wrl,
                         output logic flt);
    logic got;
    @(negedge CLK);
    bus.Start  = 1'b1;
    bus.Write  = w;
    bus.Size   = sz;
    bus.Signed = sg;
    bus.Addr   = a;
    bus.WData  = wd;
    @(posedge CLK);
    #1;
    bus.Start = 1'b0;
    lat = 0;
    rdl = 0;
    wrl = 0;
    flt = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      lat++;
      if (!bus.RD) rdl++;
      if (!bus.WR) wrl++;
      if (bus.Done) begin
        got = 1'b1;
        flt = bus.Fault;
      end else begin
        @(posedge CLK);
        #1;
      end
    end
    if (!got) chk("timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    chk("done_clr", {30'b0, bus.Done, bus.Busy}, 32'd0);
  endtask

  int   lat, rdl, wrl;
  logic flt;
  logic [31:0] prev_ld;
  int   dcnt, rcnt, wcnt;
  logic busy3, busy4;

  initial begin
    Reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Write  = 1'b0;
    bus.Size   = 2'b00;
    bus.Signed = 1'b0;
    bus.Addr   = 32'h0;
    bus.WData  = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rst_done", {31'b0, bus.Done}, 32'd0);
    chk("rst_fault", {31'b0, bus.Fault}, 32'd0);
    chk("rst_rd", {31'b0, bus.RD}, 32'd1);
    chk("rst_wr", {31'b0, bus.WR}, 32'd1);
    chk("rst_ld", bus.LoadData, 32'h0);
    chk("rst_daddr", bus.DAddr, 32'h0);
    chk("rst_din", bus.DataIn, 32'h0);
    @(negedge CLK);
    Reset = 1'b0;

    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rdl, wrl, flt);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_wr", 32'(wrl), 32'd1);
    chk("sw_rd", 32'(rdl), 32'd0);
    chk("sw_mem", mem[4], 32'h11223344);

    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdl, wrl, flt);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_rd", 32'(rdl), 32'd1);
    chk("lw_data", bus.LoadData, 32'h11223344);

    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, lat, rdl, wrl, flt);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_rdwr", 32'(rdl * 10 + wrl), 32'd11);
    chk("sb_mem", mem[4], 32'h11AA3344);

    run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rdl, wrl, flt);
    chk("lbu", bus.LoadData, 32'h000000AA);
    run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rdl, wrl, flt);
    chk("lb", bus.LoadData, 32'hFFFFFFAA);

    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, lat, rdl, wrl, flt);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_mem", mem[4], 32'h11AABEEF);

    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rdl, wrl, flt);
    chk("lh", bus.LoadData, 32'hFFFFBEEF);
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rdl, wrl, flt);
    chk("lhu", bus.LoadData, 32'h0000BEEF);

    run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rdl, wrl, flt);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_fault", {31'b0, flt}, 32'd1);
    chk("mis_rd", 32'(rdl + wrl), 32'd0);
    chk("mis_ld", bus.LoadData, 32'h0000BEEF);
    prev_ld = 32'h0000BEEF;
`else
    chk("mis_lat", 32'(lat), 32'd2);
    chk("mis_fault", {31'b0, flt}, 32'd0);
    chk("mis_ld", bus.LoadData, 32'h11AABEEF);
    prev_ld = 32'h11AABEEF;
`endif

    run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rdl, wrl, flt);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_fault", {31'b0, flt}, 32'd1);
    chk("ill_mem", 32'(rdl + wrl), 32'd0);
    chk("ill_ld", bus.LoadData, prev_ld);

    @(negedge CLK);
    bus.Start = 1'b1;
    bus.Write = 1'b1;
    bus.Size  = 2'b10;
    bus.Addr  = 32'h20;
    bus.WData = 32'hDEADBEEF;
    @(posedge CLK);
    #1;
    bus.Start = 1'b0;
    chk("rw_wr_low", {31'b0, bus.WR}, 32'd0);
    #1;
    Reset = 1'b1;
    #1;
    chk("rw_rd", {31'b0, bus.RD}, 32'd1);
    chk("rw_wr", {31'b0, bus.WR}, 32'd1);
    chk("rw_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rw_ld", bus.LoadData, 32'h0);
    #1;
    Reset = 1'b0;
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rdl, wrl, flt);
    chk("rw_load", bus.LoadData, 32'h0);
    chk("rw_mem", mem[8], 32'h0);

    dcnt = 0;
    rcnt = 0;
    wcnt = 0;
    busy3 = 1'b1;
    busy4 = 1'b0;
    @(negedge CLK);
    bus.Start = 1'b1;
    bus.Write = 1'b1;
    bus.Size  = 2'b00;
    bus.Addr  = 32'h14;
    bus.WData = 32'h00000055;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK);
      #1;
      if (k == 3) busy3 = bus.Busy;
      if (k == 4) begin
        busy4 = bus.Busy;
        bus.Start = 1'b0;
      end
      if (bus.Done) dcnt++;
      if (!bus.RD) rcnt++;
      if (!bus.WR) wcnt++;
    end
    chk("hold_idle", {31'b0, busy3}, 32'd0);
    chk("hold_restart", {31'b0, busy4}, 32'd1);
    chk("hold_dones", 32'(dcnt), 32'd2);
    chk("hold_rd", 32'(rcnt), 32'd2);
    chk("hold_wr", 32'(wcnt), 32'd2);
    chk("hold_mem", mem[5], 32'h55000000);

    chk("rd_wr_overlap", 32'(bothlow), 32'd0);
    chk("fault_wo_done", 32'(badflt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
